tm1638_serial_driver: RTL

Write-only serial driver for the TM1638 LED/key board, directly downstream of the digit-to-segment encoders. It snapshots eight segment bytes, eight LED bits and brightness, then performs a full display refresh on the 3-wire TM1638 bus (STB/CLK/DIO). Each refresh sends three frames: data command, address plus 16 data bytes, and display control. Key scanning is not supported.

---
 rtl/tm1638_serial_driver.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/tm1638_serial_driver.sv
// Write-only TM1638 display refresher: snapshots segment bytes, LEDs and
// brightness on start, then sends the data-command, address+data and
// display-control frames over the STB/CLK/DIO bus, LSB first.
module tm1638_serial_driver #(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] seg_data,
  input  logic [7:0]  led,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  output logic        busy,
  output logic        done,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio
);

  typedef enum logic [2:0] {IDLE, SETUP, BIT_LO, BIT_HI, GAP, FIN} state_t;
  typedef enum logic [1:0] {F_CMD, F_DATA, F_CTRL} frame_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state;
  frame_t      frame;
  logic [15:0] div_cnt;
  logic [2:0]  bit_idx;
  logic [4:0]  byte_idx;

  logic [63:0] seg_sh;
  logic [7:0]  led_sh;
  logic [2:0]  bri_sh;
  logic        on_sh;

  logic        phase_end;
  logic        last_byte;
  logic [2:0]  nxt_bit_idx;
  logic [4:0]  nxt_byte_idx;
  logic [3:0]  data_idx;
  logic [7:0]  tx_byte;
  logic        tx_bit;

  assign phase_end = (div_cnt == DIV_LAST);
  assign last_byte = (frame == F_DATA) ? (byte_idx == 5'd17) : (byte_idx == 5'd0);

  // Position of the bit that will be driven on the next BIT_LO entry.
  always_comb begin
    nxt_bit_idx  = bit_idx;
    nxt_byte_idx = byte_idx;
    if (state == BIT_HI) begin
      if (bit_idx == 3'd7) begin
        nxt_bit_idx  = 3'd0;
        nxt_byte_idx = byte_idx + 5'd1;
      end else begin
        nxt_bit_idx = bit_idx + 3'd1;
      end
    end
  end

  // Byte content of the frame; F2 is address 0xC0, 16 seg/led bytes and a
  // trailing 0x00 filler that lands past address 0x0F and is discarded.
  always_comb begin
    data_idx = nxt_byte_idx[3:0] - 4'd1;
    tx_byte  = 8'h00;
    case (frame)
      F_CMD:  tx_byte = 8'h40;
      F_DATA: begin
        if (nxt_byte_idx == 5'd0) begin
          tx_byte = 8'hC0;
        end else if (nxt_byte_idx <= 5'd16) begin
          if (data_idx[0] == 1'b0) begin
            tx_byte = seg_sh[{data_idx[3:1], 3'b000} +: 8];
          end else begin
            tx_byte = {7'b0, led_sh[data_idx[3:1]]};
          end
        end
      end
      F_CTRL: tx_byte = {4'h8, on_sh, bri_sh};
      default: tx_byte = 8'h00;
    endcase
    tx_bit = tx_byte[nxt_bit_idx];
  end

  // Bus sequencer: each phase lasts CLK_DIV cycles, outputs set on phase entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame    <= F_CMD;
      div_cnt  <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 5'd0;
      seg_sh   <= 64'd0;
      led_sh   <= 8'd0;
      bri_sh   <= 3'd0;
      on_sh    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tm_stb   <= 1'b1;
      tm_clk   <= 1'b1;
      tm_dio   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            seg_sh   <= seg_data;
            led_sh   <= led;
            bri_sh   <= brightness;
            on_sh    <= display_on;
            state    <= SETUP;
            frame    <= F_CMD;
            div_cnt  <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 5'd0;
            busy     <= 1'b1;
            tm_stb   <= 1'b0;
            tm_clk   <= 1'b1;
            tm_dio   <= 1'b1;
          end
        end
        SETUP: begin
          if (phase_end) begin
            div_cnt <= 16'd0;
            state   <= BIT_LO;
            tm_clk  <= 1'b0;
            tm_dio  <= tx_bit;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        BIT_LO: begin
          if (phase_end) begin
            div_cnt <= 16'd0;
            state   <= BIT_HI;
            tm_clk  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        BIT_HI: begin
          if (phase_end) begin
            div_cnt <= 16'd0;
            if (bit_idx == 3'd7 && last_byte) begin
              state    <= GAP;
              bit_idx  <= 3'd0;
              byte_idx <= 5'd0;
              tm_stb   <= 1'b1;
              tm_clk   <= 1'b1;
              tm_dio   <= 1'b1;
            end else begin
              state    <= BIT_LO;
              bit_idx  <= nxt_bit_idx;
              byte_idx <= nxt_byte_idx;
              tm_clk   <= 1'b0;
              tm_dio   <= tx_bit;
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        GAP: begin
          if (phase_end) begin
            div_cnt <= 16'd0;
            case (frame)
              F_CMD: begin
                frame  <= F_DATA;
                state  <= SETUP;
                tm_stb <= 1'b0;
              end
              F_DATA: begin
                frame  <= F_CTRL;
                state  <= SETUP;
                tm_stb <= 1'b0;
              end
              default: begin
                frame <= F_CMD;
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            endcase
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
